// File: rtl/mmul_sched_pkg.sv
// Shared constants for the 3x3 matrix-multiply scheduler: element/matrix widths,
// FSM state encoding and the flattened element index helper.
package mmul_sched_pkg;

  localparam int ELEM_W = 8;
  localparam int DIM    = 3;
  localparam int NELEM  = DIM * DIM;
  localparam int MAT_W  = NELEM * ELEM_W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  // Element (i,j) sits at bits elem_lsb(i,j,w) +: w of a flattened matrix.
  function automatic int elem_lsb(input int i, input int j, input int w);
    return (i * DIM + j) * w;
  endfunction

endpackage

// File: rtl/mmul_rr_arb.sv
// 2-way round-robin arbiter: combinational one-hot grant from valid, pointer moves on accept.
// Zero latency; grant is only a suggestion until the caller asserts accept.
module mmul_rr_arb (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  // prio1 set means requester 1 wins the next tie (requester 0 was served last)
  logic prio1;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = prio1 ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk) begin
    if (reset) prio1 <= 1'b0;
    else if (accept && (req != 2'b00)) prio1 <= grant[0];
  end

endmodule

// File: rtl/mmul_sched.sv
// Two-requester scheduler for one shared 3x3 mmul engine with done/timeout handling.
// Response one cycle after done (or timeout); requesters are held off (ready=0) while a job is in flight.
module mmul_sched
  import mmul_sched_pkg::*;
#(
  parameter int TIMEOUT = 64,
  parameter int W       = ELEM_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               r0_valid,
  output logic               r0_ready,
  input  logic [NELEM*W-1:0] r0_mat_a,
  input  logic [NELEM*W-1:0] r0_mat_b,
  output logic               r0_rsp_valid,
  output logic [NELEM*W-1:0] r0_rsp_data,
  output logic               r0_rsp_err,
  input  logic               r1_valid,
  output logic               r1_ready,
  input  logic [NELEM*W-1:0] r1_mat_a,
  input  logic [NELEM*W-1:0] r1_mat_b,
  output logic               r1_rsp_valid,
  output logic [NELEM*W-1:0] r1_rsp_data,
  output logic               r1_rsp_err,
  output logic               eng_enable,
  output logic [NELEM*W-1:0] eng_mat_a,
  output logic [NELEM*W-1:0] eng_mat_b,
  input  logic [NELEM*W-1:0] eng_result,
  input  logic               eng_done
);

  localparam int MW = NELEM * W;
  localparam int CW = $clog2(TIMEOUT) + 1;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          owner;
  logic [1:0]    grant;
  logic          idle;
  logic          timeout_hit;

  assign idle        = (state == ST_IDLE) && !reset;
  assign r0_ready    = idle && grant[0];
  assign r1_ready    = idle && grant[1];
  assign eng_enable  = (state == ST_BUSY);
  assign timeout_hit = (cnt == CW'(TIMEOUT - 1));

  mmul_rr_arb u_arb (
    .clk    (clk),
    .reset  (reset),
    .req    ({r1_valid, r0_valid}),
    .accept (idle),
    .grant  (grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      owner        <= 1'b0;
      eng_mat_a    <= '0;
      eng_mat_b    <= '0;
      r0_rsp_valid <= 1'b0;
      r0_rsp_data  <= '0;
      r0_rsp_err   <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r1_rsp_data  <= '0;
      r1_rsp_err   <= 1'b0;
    end else begin
      r0_rsp_valid <= 1'b0;
      r1_rsp_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (grant != 2'b00) begin
            owner     <= grant[1];
            eng_mat_a <= grant[1] ? r1_mat_a : r0_mat_a;
            eng_mat_b <= grant[1] ? r1_mat_b : r0_mat_b;
            cnt       <= '0;
            state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          // done takes precedence over a timeout landing in the same cycle
          if (eng_done || timeout_hit) begin
            state <= ST_RELEASE;
            if (owner) begin
              r1_rsp_valid <= 1'b1;
              r1_rsp_data  <= eng_done ? eng_result : MW'(0);
              r1_rsp_err   <= !eng_done;
            end else begin
              r0_rsp_valid <= 1'b1;
              r0_rsp_data  <= eng_done ? eng_result : MW'(0);
              r0_rsp_err   <= !eng_done;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (!eng_done) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mmul_sched.sv
// Self-checking bench for mmul_sched: elementwise-sum engine model with programmable
// done latency/hold, randomized operands, expectations derived from cycle-level rules.
module tb_mmul_sched;
  import mmul_sched_pkg::*;

  localparam int W  = 8;
  localparam int TO = 16;
  localparam int MW = NELEM * W;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]    rv = 2'b00;
  logic [MW-1:0] ma0 = '0, mb0 = '0, ma1 = '0, mb1 = '0;
  logic [1:0]    rdy;
  logic          rsv0, rsv1, rerr0, rerr1;
  logic [MW-1:0] rd0, rd1;
  logic          eng_enable;
  logic          eng_done = 1'b0;
  logic [MW-1:0] eng_a, eng_b, eng_result;

  int checks = 0;
  int passed = 0;
  int cyc = 0;

  int eng_lat = 1;
  int eng_hold = 0;
  bit eng_never = 1'b0;
  int en_cnt = 0;
  int hold_left = 0;

  localparam logic [MW-1:0] DA = {8'd1, 8'd2, 8'd3, 8'd1, 8'd0, 8'd5, 8'd3, 8'd8, 8'd2};
  localparam logic [MW-1:0] DB = {8'd0, 8'd0, 8'd3, 8'd5, 8'd6, 8'd1, 8'd2, 8'd0, 8'd8};
  localparam logic [MW-1:0] DE = {8'd1, 8'd2, 8'd6, 8'd6, 8'd6, 8'd6, 8'd5, 8'd8, 8'd10};

  function automatic logic [MW-1:0] ref_sum(input logic [MW-1:0] a, input logic [MW-1:0] b);
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        r[elem_lsb(i, j, W) +: W] = a[elem_lsb(i, j, W) +: W] + b[elem_lsb(i, j, W) +: W];
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mat();
    logic [MW-1:0] r;
    r = '0;
    for (int i = 0; i < NELEM; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  mmul_sched #(.TIMEOUT(TO), .W(W)) dut (
    .clk          (clk),
    .reset        (reset),
    .r0_valid     (rv[0]),
    .r0_ready     (rdy[0]),
    .r0_mat_a     (ma0),
    .r0_mat_b     (mb0),
    .r0_rsp_valid (rsv0),
    .r0_rsp_data  (rd0),
    .r0_rsp_err   (rerr0),
    .r1_valid     (rv[1]),
    .r1_ready     (rdy[1]),
    .r1_mat_a     (ma1),
    .r1_mat_b     (mb1),
    .r1_rsp_valid (rsv1),
    .r1_rsp_data  (rd1),
    .r1_rsp_err   (rerr1),
    .eng_enable   (eng_enable),
    .eng_mat_a    (eng_a),
    .eng_mat_b    (eng_b),
    .eng_result   (eng_result),
    .eng_done     (eng_done)
  );

  // Engine model: done rises after eng_lat enabled cycles, lingers eng_hold cycles past enable drop.
  assign eng_result = ref_sum(eng_a, eng_b);
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      en_cnt <= 0; hold_left <= 0; eng_done <= 1'b0;
    end else if (eng_enable) begin
      en_cnt <= en_cnt + 1;
      if (!eng_never && en_cnt + 1 >= eng_lat) begin
        eng_done <= 1'b1; hold_left <= eng_hold;
      end
    end else begin
      en_cnt <= 0;
      if (hold_left > 0) hold_left <= hold_left - 1;
      else eng_done <= 1'b0;
    end
  end

  // Ready must be exclusive and only offered while the engine is idle and quiet.
  always @(negedge clk) begin
    #2;
    if (!reset) begin
      checks++;
      if (rdy == 2'b11 || (rdy != 2'b00 && (eng_done || eng_enable)))
        $display("FAIL ready_excl: cyc=%0d rdy=%b done=%b en=%b, want exclusive ready only when idle", cyc, rdy, eng_done, eng_enable);
      else passed++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_job(input int req, input logic [MW-1:0] a, input logic [MW-1:0] b,
                        input int lat, input int hold, input bit never,
                        output int acc_c, output int en_c, output int rsp_c,
                        output logic [MW-1:0] data, output logic err, output bit other,
                        output bit en_at_rsp, output bit pulse2);
    eng_lat = lat; eng_hold = hold; eng_never = never;
    acc_c = -1; en_c = -1; rsp_c = -1; data = '0; err = 1'b0;
    other = 1'b0; en_at_rsp = 1'b1; pulse2 = 1'b1;
    @(negedge clk);
    if (req == 0) begin ma0 = a; mb0 = b; end
    else begin ma1 = a; mb1 = b; end
    rv[req] = 1'b1;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (rdy[req]) begin acc_c = cyc; break; end
      @(negedge clk);
    end
    @(negedge clk);
    rv[req] = 1'b0;
    if (acc_c < 0) return;
    #1;
    if (eng_enable) en_c = cyc;
    for (int k = 0; k < 200; k++) begin
      if (req == 0 ? rsv1 : rsv0) other = 1'b1;
      if (req == 0 ? rsv0 : rsv1) begin
        rsp_c = cyc;
        data = (req == 0) ? rd0 : rd1;
        err = (req == 0) ? rerr0 : rerr1;
        en_at_rsp = eng_enable;
        break;
      end
      @(negedge clk); #1;
    end
    if (rsp_c >= 0) begin
      @(negedge clk); #1;
      pulse2 = (req == 0) ? rsv0 : rsv1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    rv = 2'b11; ma0 = rand_mat(); mb0 = rand_mat(); ma1 = rand_mat(); mb1 = rand_mat();
    @(negedge clk); @(negedge clk); #1;
    checks++; if (rdy !== 2'b00) $display("FAIL rst_ready: got %b want 00", rdy); else passed++;
    checks++; if (eng_enable !== 1'b0) $display("FAIL rst_enable: got %b want 0", eng_enable); else passed++;
    checks++; if (eng_a !== '0 || eng_b !== '0) $display("FAIL rst_eng_mat: got %h/%h want 0", eng_a, eng_b); else passed++;
    checks++; if ({rsv0, rsv1, rerr0, rerr1} !== 4'b0) $display("FAIL rst_rsp_flags: got %b want 0000", {rsv0, rsv1, rerr0, rerr1}); else passed++;
    checks++; if (rd0 !== '0 || rd1 !== '0) $display("FAIL rst_rsp_data: got %h/%h want 0", rd0, rd1); else passed++;
    rv = 2'b00;
    reset = 1'b0;
  endtask

  task automatic test_directed();
    int acc, en, rsp; logic [MW-1:0] d; logic e; bit oth, enr, p2;
    do_job(0, DA, DB, 10, 0, 1'b0, acc, en, rsp, d, e, oth, enr, p2);
    checks++; if (en !== acc + 1 || acc < 0) $display("FAIL dir_enable_rise: en=%0d acc=%0d want en=acc+1", en, acc); else passed++;
    checks++; if (rsp - en !== 11) $display("FAIL dir_latency: got %0d want 11", rsp - en); else passed++;
    checks++; if (d !== DE) $display("FAIL dir_data: got %h want %h", d, DE); else passed++;
    checks++; if (e !== 1'b0) $display("FAIL dir_err: got %b want 0", e); else passed++;
    checks++; if (p2 !== 1'b0 || oth !== 1'b0) $display("FAIL dir_pulse: next=%b other=%b want 0/0", p2, oth); else passed++;
    checks++; if (enr !== 1'b0) $display("FAIL dir_enable_drop: got %b want 0", enr); else passed++;
  endtask

  task automatic test_random();
    int acc, en, rsp, req, lat; logic [MW-1:0] a, b, d; logic e; bit oth, enr, p2;
    for (int n = 0; n < 20; n++) begin
      req = int'($urandom_range(0, 1));
      lat = (n == 0) ? 1 : (n == 1) ? TO - 1 : int'($urandom_range(1, TO - 1));
      a = rand_mat(); b = rand_mat();
      do_job(req, a, b, lat, int'($urandom_range(0, 2)), 1'b0, acc, en, rsp, d, e, oth, enr, p2);
      checks++; if (rsp - en !== lat + 1 || rsp < 0) $display("FAIL rnd_latency[%0d]: got %0d want %0d", n, rsp - en, lat + 1); else passed++;
      checks++; if (d !== ref_sum(a, b) || e !== 1'b0) $display("FAIL rnd_data[%0d]: got %h err=%b want %h err=0", n, d, e, ref_sum(a, b)); else passed++;
      checks++; if (oth !== 1'b0 || p2 !== 1'b0) $display("FAIL rnd_owner[%0d]: other=%b next=%b want 0/0", n, oth, p2); else passed++;
    end
  endtask

  task automatic test_timeout();
    int acc, en, rsp; logic [MW-1:0] a, b, d; logic e; bit oth, enr, p2;
    do_job(1, rand_mat(), rand_mat(), 1, 0, 1'b1, acc, en, rsp, d, e, oth, enr, p2);
    checks++; if (rsp - en !== TO || rsp < 0) $display("FAIL to_latency: got %0d want %0d", rsp - en, TO); else passed++;
    checks++; if (e !== 1'b1 || d !== '0) $display("FAIL to_resp: err=%b data=%h want 1/0", e, d); else passed++;
    checks++; if (enr !== 1'b0 || p2 !== 1'b0) $display("FAIL to_drop: en=%b next=%b want 0/0", enr, p2); else passed++;
    // done arriving one cycle after the timeout cycle still loses
    do_job(0, rand_mat(), rand_mat(), TO, 0, 1'b0, acc, en, rsp, d, e, oth, enr, p2);
    checks++; if (e !== 1'b1 || d !== '0 || rsp - en !== TO) $display("FAIL to_late_done: err=%b data=%h lat=%0d want 1/0/%0d", e, d, rsp - en, TO); else passed++;
    a = rand_mat(); b = rand_mat();
    do_job(1, a, b, 4, 0, 1'b0, acc, en, rsp, d, e, oth, enr, p2);
    checks++; if (e !== 1'b0 || d !== ref_sum(a, b) || rsp - en !== 5) $display("FAIL to_recover: err=%b data=%h lat=%0d want 0/%h/5", e, d, rsp - en, ref_sum(a, b)); else passed++;
  endtask

  task automatic test_back_to_back();
    int exp_seq[3] = '{0, 1, 0};
    int g, own; logic [MW-1:0] expd, d;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    eng_lat = 3; eng_hold = 0; eng_never = 1'b0;
    ma0 = rand_mat(); mb0 = rand_mat(); ma1 = rand_mat(); mb1 = rand_mat();
    rv = 2'b11;
    for (int j = 0; j < 3; j++) begin
      g = -1;
      for (int k = 0; k < 100; k++) begin
        #1;
        if (rdy != 2'b00) begin g = int'(rdy[1]); break; end
        @(negedge clk);
      end
      checks++; if (g !== exp_seq[j]) $display("FAIL b2b_grant[%0d]: got %0d want %0d", j, g, exp_seq[j]); else passed++;
      expd = (g == 1) ? ref_sum(ma1, mb1) : ref_sum(ma0, mb0);
      @(negedge clk);
      if (j == 2) rv = 2'b00;
      else if (g == 1) begin ma1 = rand_mat(); mb1 = rand_mat(); end
      else begin ma0 = rand_mat(); mb0 = rand_mat(); end
      own = -1; d = '0;
      for (int k = 0; k < 100; k++) begin
        #1;
        if (rsv0 || rsv1) begin own = int'(rsv1); d = rsv1 ? rd1 : rd0; break; end
        @(negedge clk);
      end
      checks++; if (own !== g || d !== expd) $display("FAIL b2b_rsp[%0d]: owner=%0d data=%h want %0d/%h", j, own, d, g, expd); else passed++;
    end
    rv = 2'b00;
  endtask

  task automatic test_release_hold();
    int acc, en, rsp, acc1, r1c; logic [MW-1:0] a, b, d, e1; logic e; bit oth, enr, p2;
    do_job(1, rand_mat(), rand_mat(), 2, 0, 1'b0, acc, en, rsp, d, e, oth, enr, p2);
    ma1 = rand_mat(); mb1 = rand_mat(); e1 = ref_sum(ma1, mb1);
    rv[1] = 1'b1;
    a = rand_mat(); b = rand_mat();
    do_job(0, a, b, 4, 2, 1'b0, acc, en, rsp, d, e, oth, enr, p2);
    checks++; if (d !== ref_sum(a, b) || rsp - en !== 5) $display("FAIL hold_r0: data=%h lat=%0d want %h/5", d, rsp - en, ref_sum(a, b)); else passed++;
    acc1 = -1;
    for (int k = 0; k < 100; k++) begin
      if (rdy[1]) begin acc1 = cyc; break; end
      @(negedge clk); #1;
    end
    checks++; if (acc1 !== rsp + 4 || rsp < 0) $display("FAIL hold_regrant: got cycle %0d want %0d", acc1, rsp + 4); else passed++;
    @(negedge clk); rv[1] = 1'b0;
    r1c = -1; d = '0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (rsv1) begin r1c = cyc; d = rd1; break; end
      @(negedge clk);
    end
    checks++; if (r1c < 0 || d !== e1) $display("FAIL hold_r1: data=%h want %h", d, e1); else passed++;
  endtask

  task automatic test_reset_busy();
    int acc, en, rsp; logic [MW-1:0] d, e0; logic e; bit oth, enr, p2, seen, got;
    do_job(0, rand_mat(), rand_mat(), 2, 0, 1'b0, acc, en, rsp, d, e, oth, enr, p2);
    eng_lat = 10; eng_hold = 0; eng_never = 1'b0;
    @(negedge clk); ma1 = rand_mat(); mb1 = rand_mat(); rv[1] = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (rdy[1]) begin got = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (got !== 1'b1) $display("FAIL rb_grant_r1: got %b want 1", got); else passed++;
    @(negedge clk); rv[1] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0; #1;
    checks++; if (eng_enable !== 1'b0) $display("FAIL rb_enable: got %b want 0", eng_enable); else passed++;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rsv0 || rsv1) seen = 1'b1;
      @(negedge clk); #1;
    end
    checks++; if (seen !== 1'b0 || rd1 !== '0) $display("FAIL rb_no_rsp: seen=%b data=%h want 0/0", seen, rd1); else passed++;
    @(negedge clk);
    ma0 = rand_mat(); mb0 = rand_mat(); e0 = ref_sum(ma0, mb0); rv = 2'b11;
    #1;
    checks++; if (rdy !== 2'b01) $display("FAIL rb_prio: got %b want 01", rdy); else passed++;
    @(negedge clk); rv = 2'b00;
    d = '0; got = 1'b0;
    for (int k = 0; k < 100; k++) begin
      #1;
      if (rsv0) begin d = rd0; got = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (got !== 1'b1 || d !== e0) $display("FAIL rb_after: got=%b data=%h want 1/%h", got, d, e0); else passed++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_timeout();
    test_back_to_back();
    test_release_hold();
    test_reset_busy();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
